// File: rtl/mmio_address_router.sv
// rtl/mmio_address_router.sv - base/mask MMIO router with latched read steering, error response and read timeout
module mmio_address_router #(
    parameter int                                  NUM_SLAVES     = 4,
    parameter int                                  ADDR_WIDTH     = 32,
    parameter int                                  DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    REGION_BASE    = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    REGION_MASK    = '0,
    parameter int                                  DEFAULT_SLAVE  = NUM_SLAVES - 1,
    parameter logic [DATA_WIDTH-1:0]               ERR_DATA       = DATA_WIDTH'(32'hDEADBEEF),
    parameter int                                  TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               m_cmd_start,
    input  logic                               m_cmd_write,
    output logic                               m_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]              m_addr,
    input  logic [DATA_WIDTH-1:0]              m_wdata,
    output logic [DATA_WIDTH-1:0]              m_rdata,
    output logic                               m_rdata_valid,
    output logic                               m_err,
    output logic [NUM_SLAVES-1:0]              s_cmd_start,
    output logic [NUM_SLAVES-1:0]              s_cmd_write,
    input  logic [NUM_SLAVES-1:0]              s_cmd_ready,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   s_addr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]              s_rdata_valid
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit LP_HAS_DEFAULT = (DEFAULT_SLAVE < NUM_SLAVES);
    localparam logic [SW-1:0] LP_DEF_SEL = SW'(LP_HAS_DEFAULT ? DEFAULT_SLAVE : 0);
    localparam logic [CW-1:0] LP_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit LP_TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_ERR_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SW-1:0]          r_sel;
    logic [CW-1:0]          r_cnt;
    logic                   r_werr;

    logic [NUM_SLAVES-1:0]  w_hit;
    logic                   w_found;
    logic [SW-1:0]          w_hit_sel;
    logic                   w_default;
    logic                   w_routed;
    logic [SW-1:0]          w_sel;
    logic                   w_sel_ready;
    logic                   w_lat_valid;
    logic [DATA_WIDTH-1:0]  w_lat_data;
    logic                   w_expire;
    logic                   w_rd_err;
    logic                   w_accept;

    // Per-region hit, offset address and write-data broadcast
    genvar g;
    generate
        for (g = 0; g < NUM_SLAVES; g++) begin : g_region
            assign w_hit[g] = (m_addr & REGION_MASK[g*ADDR_WIDTH +: ADDR_WIDTH])
                              == REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
            // The default route carries the raw address; a real hit carries the region offset
            assign s_addr[g*ADDR_WIDTH +: ADDR_WIDTH] =
                (w_default && (w_sel == SW'(g))) ? m_addr
                                                 : m_addr - REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign s_wdata[g*DATA_WIDTH +: DATA_WIDTH] = m_wdata;
        end
    endgenerate

    // Priority decode: lowest hit index wins
    always_comb begin
        w_found   = 1'b0;
        w_hit_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!w_found && w_hit[i]) begin
                w_found   = 1'b1;
                w_hit_sel = SW'(i);
            end
        end
    end

    assign w_default = !w_found && LP_HAS_DEFAULT;
    assign w_routed  = w_found || w_default;
    assign w_sel     = w_found ? w_hit_sel : LP_DEF_SEL;
    assign w_expire  = LP_TIMEOUT_ON && (r_cnt == LP_LAST);
    assign w_accept  = m_cmd_start && m_cmd_ready;

    // Pick ready of the decoded slave and read response of the latched slave
    always_comb begin
        w_sel_ready = 1'b0;
        w_lat_valid = 1'b0;
        w_lat_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_sel == SW'(i)) begin
                w_sel_ready = s_cmd_ready[i];
            end
            if (r_sel == SW'(i)) begin
                w_lat_valid = s_rdata_valid[i];
                w_lat_data  = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Command steering and read response; everything is held at 0 while in reset
    always_comb begin
        s_cmd_start   = '0;
        s_cmd_write   = '0;
        m_cmd_ready   = 1'b0;
        m_rdata       = '0;
        m_rdata_valid = 1'b0;
        w_rd_err      = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_routed) begin
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            if (w_sel == SW'(i)) begin
                                s_cmd_start[i] = m_cmd_start;
                                s_cmd_write[i] = m_cmd_write;
                            end
                        end
                        m_cmd_ready = w_sel_ready;
                    end else begin
                        m_cmd_ready = 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    // A real response in the expiry cycle beats the timeout
                    if (w_lat_valid) begin
                        m_rdata_valid = 1'b1;
                        m_rdata       = w_lat_data;
                    end else if (w_expire) begin
                        m_rdata_valid = 1'b1;
                        m_rdata       = ERR_DATA;
                        w_rd_err      = 1'b1;
                    end
                end
                ST_ERR_RESP: begin
                    m_rdata_valid = 1'b1;
                    m_rdata       = ERR_DATA;
                    w_rd_err      = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign m_err = rst_n && (w_rd_err || r_werr);

    // Read-tracking FSM: latch target on accept, count wait cycles, return to IDLE on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_werr  <= 1'b0;
        end else begin
            r_werr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_routed) begin
                            if (!m_cmd_write) begin
                                r_sel   <= w_sel;
                                r_cnt   <= '0;
                                r_state <= ST_RD_WAIT;
                            end
                        end else if (m_cmd_write) begin
                            r_werr <= 1'b1;
                        end else begin
                            r_state <= ST_ERR_RESP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_lat_valid || w_expire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_ERR_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_address_router.sv
// tb/tb_mmio_address_router.sv - randomized self-checking bench for mmio_address_router
module tb_mmio_address_router;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;
    localparam logic [N*AW-1:0] BASES = {32'h0000_0000, 32'hF000_0100, 32'hF000_0000};
    localparam logic [N*AW-1:0] MASKS = {32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    logic           clk;
    logic           rst_n;
    logic           m_cmd_start;
    logic           m_cmd_write;
    logic           m_cmd_ready;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [DW-1:0]  m_rdata;
    logic           m_rdata_valid;
    logic           m_err;
    logic [N-1:0]   s_cmd_start;
    logic [N-1:0]   s_cmd_write;
    logic [N-1:0]   s_cmd_ready;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]   s_rdata_valid;

    int checks;
    int failures;

    logic [31:0] ref_base [N] = '{32'hF000_0000, 32'hF000_0100, 32'h0000_0000};
    logic [31:0] ref_mask [N] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000};

    mmio_address_router #(
        .NUM_SLAVES     (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .REGION_BASE    (BASES),
        .REGION_MASK    (MASKS),
        .DEFAULT_SLAVE  (3),
        .ERR_DATA       (ERRV),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_cmd_start   (m_cmd_start),
        .m_cmd_write   (m_cmd_write),
        .m_cmd_ready   (m_cmd_ready),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_rdata_valid (m_rdata_valid),
        .m_err         (m_err),
        .s_cmd_start   (s_cmd_start),
        .s_cmd_write   (s_cmd_write),
        .s_cmd_ready   (s_cmd_ready),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_rdata_valid (s_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Which slave owns an address: first table entry that matches, -1 if none
    function automatic int ref_route(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int s);
        logic [31:0] v;
        v = 32'd0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        int cls;
        cls = $urandom_range(0, 4);
        case (cls)
            0: return 32'hF000_0000 | 32'($urandom_range(0, 255));
            1: return 32'hF000_0100 | 32'($urandom_range(0, 255));
            2: return $urandom & 32'h0FFF_FFFF;
            3: return {4'($urandom_range(1, 14)), 28'($urandom)};
            default: return 32'hF000_0200 | 32'($urandom_range(0, 32'h00FF_FDFF));
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rwait, input int lat,
                           input logic [31:0] data, input bit force_noise);
        int  s;
        bit  acc;
        bit  done;
        s = ref_route(addr);
        for (int c = 0; c <= rwait; c++) begin
            m_cmd_start   = 1'b1;
            m_cmd_write   = 1'b0;
            m_addr        = addr;
            s_cmd_ready   = N'($urandom);
            s_rdata_valid = N'($urandom);
            s_rdata       = {$urandom, $urandom, $urandom};
            acc = (s < 0) || (c >= rwait);
            if (s >= 0) s_cmd_ready[s] = (c >= rwait);
            #1;
            check("rd_s_start", 32'(s_cmd_start), onehot(s));
            check("rd_idle_valid", 32'(m_rdata_valid), 32'd0);
            check("rd_ready", 32'(m_cmd_ready), 32'(acc));
            if (s >= 0) check("rd_s_addr", s_addr[s*AW +: AW], addr - ref_base[s]);
            next_cycle();
            if (acc) break;
        end
        m_cmd_start = 1'b0;
        if (s < 0) begin
            s_cmd_ready   = '0;
            s_rdata_valid = N'($urandom);
            #1;
            check("err_valid", 32'(m_rdata_valid), 32'd1);
            check("err_rdata", m_rdata, ERRV);
            check("err_err", 32'(m_err), 32'd1);
            next_cycle();
        end else begin
            done = 1'b0;
            for (int k = 1; k <= T && !done; k++) begin
                m_cmd_start   = 1'($urandom_range(0, 1));
                m_addr        = force_noise ? 32'hF000_0000 : $urandom;
                s_cmd_ready   = N'($urandom);
                s_rdata       = {$urandom, $urandom, $urandom};
                s_rdata_valid = force_noise ? {N{1'b1}} : N'($urandom);
                s_rdata_valid[s] = (k == lat);
                if (k == lat) s_rdata[s*DW +: DW] = data;
                #1;
                check("wait_ready", 32'(m_cmd_ready), 32'd0);
                check("wait_s_start", 32'(s_cmd_start), 32'd0);
                if (k == lat) begin
                    check("rsp_valid", 32'(m_rdata_valid), 32'd1);
                    check("rsp_rdata", m_rdata, data);
                    check("rsp_err", 32'(m_err), 32'd0);
                    done = 1'b1;
                end else if (k == T) begin
                    check("tmo_valid", 32'(m_rdata_valid), 32'd1);
                    check("tmo_rdata", m_rdata, ERRV);
                    check("tmo_err", 32'(m_err), 32'd1);
                    done = 1'b1;
                end else begin
                    check("wait_valid", 32'(m_rdata_valid), 32'd0);
                    check("wait_rdata", m_rdata, 32'd0);
                    check("wait_err", 32'(m_err), 32'd0);
                end
                next_cycle();
            end
        end
        // Back in IDLE: a late or stray response must be ignored
        m_cmd_start   = 1'b0;
        s_cmd_ready   = '0;
        s_rdata_valid = N'($urandom);
        if (s >= 0) s_rdata_valid[s] = 1'b1;
        #1;
        check("post_valid", 32'(m_rdata_valid), 32'd0);
        check("post_rdata", m_rdata, 32'd0);
        check("post_err", 32'(m_err), 32'd0);
        next_cycle();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int rwait);
        int s;
        bit acc;
        s = ref_route(addr);
        for (int c = 0; c <= rwait; c++) begin
            m_cmd_start   = 1'b1;
            m_cmd_write   = 1'b1;
            m_addr        = addr;
            m_wdata       = data;
            s_cmd_ready   = N'($urandom);
            s_rdata_valid = N'($urandom);
            acc = (s < 0) || (c >= rwait);
            if (s >= 0) s_cmd_ready[s] = (c >= rwait);
            #1;
            check("wr_s_start", 32'(s_cmd_start), onehot(s));
            check("wr_s_write", 32'(s_cmd_write), onehot(s));
            check("wr_ready", 32'(m_cmd_ready), 32'(acc));
            check("wr_valid", 32'(m_rdata_valid), 32'd0);
            if (s >= 0) check("wr_s_wdata", s_wdata[s*DW +: DW], data);
            next_cycle();
            if (acc) break;
        end
        // Still IDLE afterwards: ready follows the slaves again; unmapped writes flag an error now
        m_cmd_start   = 1'b0;
        m_cmd_write   = 1'b0;
        s_cmd_ready   = {N{1'b1}};
        s_rdata_valid = '0;
        #1;
        check("wr_next_err", 32'(m_err), 32'(s < 0));
        check("wr_next_valid", 32'(m_rdata_valid), 32'd0);
        check("wr_next_ready", 32'(m_cmd_ready), 32'd1);
        next_cycle();
    endtask

    task automatic reset_mid_read();
        m_cmd_start = 1'b1;
        m_cmd_write = 1'b0;
        m_addr      = 32'hF000_0104;
        s_cmd_ready = 3'b010;
        s_rdata_valid = '0;
        #1;
        check("rst_rd_ready", 32'(m_cmd_ready), 32'd1);
        next_cycle();
        m_cmd_start = 1'b0;
        s_cmd_ready = '0;
        #1;
        check("rst_wait_valid", 32'(m_rdata_valid), 32'd0);
        next_cycle();
        rst_n = 1'b0;
        #1;
        next_cycle();
        rst_n = 1'b1;
        s_rdata_valid = 3'b010;
        s_rdata[1*DW +: DW] = 32'h77;
        s_cmd_ready = 3'b010;
        #1;
        check("rst_valid", 32'(m_rdata_valid), 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_idle_ready", 32'(m_cmd_ready), 32'd1);
        next_cycle();
        s_rdata_valid = '0;
        s_cmd_ready   = '0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        m_cmd_start   = 1'b0;
        m_cmd_write   = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        s_cmd_ready   = '0;
        s_rdata       = '0;
        s_rdata_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", 32'(m_rdata_valid), 32'd0);
        check("reset_err", 32'(m_err), 32'd0);
        check("reset_rdata", m_rdata, 32'd0);
        check("reset_s_start", 32'(s_cmd_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(m_cmd_ready), 32'd0);
        check("idle_valid", 32'(m_rdata_valid), 32'd0);
        next_cycle();

        do_read(32'hF000_0104, 0, 3, 32'h55, 1'b0);
        do_read(32'h0000_0010, 0, 4, 32'h1234, 1'b1);
        do_read(32'h8000_0000, 0, 1, 32'h0, 1'b0);
        do_write(32'h8000_0000, 32'h99, 0);
        do_read(32'hF000_0000, 0, T + 5, 32'h0, 1'b0);
        do_write(32'hF000_0000, 32'h41, 0);
        do_read(32'hF000_0010, 1, T, 32'hAB, 1'b0);
        do_read(32'hF000_01FF, 2, T + 1, 32'h0, 1'b0);
        do_read(32'h0FFF_FFFF, 0, 1, 32'hCAFE_0001, 1'b0);
        do_write(32'hF000_0200, 32'h5, 1);
        reset_mid_read();
        do_read(32'hF000_0108, 0, 2, 32'h66, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = rand_addr();
            if ($urandom_range(0, 2) == 0)
                do_write(a, $urandom, $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(1, T + 3), $urandom,
                        1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
